// File: rtl/test19_pkg.sv
// Shared types and constants for the Test19 pixel server.
//   state_t : server FSM states
//   call_t  : which RPC call the current transaction is serving
//   SERVER_ID_DEFAULT : value returned by get_id once started
package test19_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PX_RD = 2'd1,
    PX_WR = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CALL_START = 2'd0,
    CALL_ID    = 2'd1,
    CALL_PIXEL = 2'd2
  } call_t;

  localparam logic [15:0] SERVER_ID_DEFAULT = 16'h0013;

endpackage

// File: rtl/test19_pixel_ram.sv
// Single-port synchronous byte RAM, DEPTH x 8, 1-cycle read latency.
// Contents are not reset.
//   clk   : clock
//   we    : write enable (write wdata to addr on the rising edge)
//   addr  : word address
//   wdata : write data
//   rdata : registered read data of addr from the previous edge
module test19_pixel_ram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/test19_pixel_server.sv
// Responder end of the Test19 RPC req/ack interface: start, get_id and
// setget_pixel calls served against a WIDTH x HEIGHT byte pixel store.
//   clk                 : clock
//   reset               : asynchronous active-low reset
//   start_req/ack       : start call handshake
//   get_id_req/ack      : get_id call handshake, get_id_return = result
//   setget_pixel_req/ack: pixel call handshake
//   setget_pixel_axx/ayy: column/row (full 32-bit range check)
//   setget_pixel_readf  : 1 = read only, 0 = write wdata
//   setget_pixel_wdata  : write data
//   setget_pixel_return : pixel value before this call (0 when out of range)
module test19_pixel_server
  import test19_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned HEIGHT    = 32,
  parameter logic [15:0] SERVER_ID = SERVER_ID_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_req,
  output logic        start_ack,
  input  logic        get_id_req,
  output logic        get_id_ack,
  output logic [15:0] get_id_return,
  input  logic        setget_pixel_req,
  output logic        setget_pixel_ack,
  input  logic [31:0] setget_pixel_axx,
  input  logic [31:0] setget_pixel_ayy,
  input  logic        setget_pixel_readf,
  input  logic [7:0]  setget_pixel_wdata,
  output logic [7:0]  setget_pixel_return
);

  localparam int unsigned DEPTH = WIDTH * HEIGHT;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t        state, state_nx;
  call_t         call_q, call_sel;
  logic          call_any;
  logic          started;
  logic          readf_q;
  logic [7:0]    wdata_q;
  logic [AW-1:0] addr_q, addr_in, ram_addr;
  logic [7:0]    ram_rdata;
  logic          ram_we;
  logic          in_range;
  logic          any_ack;
  logic          cur_req;

  // Control strobes decoded from the FSM
  logic accept, do_start, do_id, do_px, do_px_oor, rd_cap, px_ack_set, resp_clr;

  assign in_range = (setget_pixel_axx < 32'(WIDTH)) && (setget_pixel_ayy < 32'(HEIGHT));
  assign addr_in  = AW'(setget_pixel_ayy * WIDTH + setget_pixel_axx);
  assign any_ack  = start_ack | get_id_ack | setget_pixel_ack;

  // Fixed priority: start > get_id > setget_pixel
  always_comb begin
    call_any = 1'b1;
    call_sel = CALL_START;
    if (start_req)             call_sel = CALL_START;
    else if (get_id_req)       call_sel = CALL_ID;
    else if (setget_pixel_req) call_sel = CALL_PIXEL;
    else                       call_any = 1'b0;
  end

  always_comb begin
    case (call_q)
      CALL_START: cur_req = start_req;
      CALL_ID:    cur_req = get_id_req;
      default:    cur_req = setget_pixel_req;
    endcase
  end

  // The read is issued straight from the live arguments while still in IDLE,
  // so the RAM data is ready by PX_RD; the write uses the latched address.
  assign ram_addr = (state == IDLE) ? addr_in : addr_q;

  test19_pixel_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (call_any && !any_ack) begin
          if (call_sel == CALL_PIXEL) state_nx = in_range ? PX_RD : RESP;
          else                        state_nx = RESP;
        end
      end
      PX_RD:   state_nx = readf_q ? RESP : PX_WR;
      PX_WR:   state_nx = RESP;
      RESP:    if (!cur_req) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    accept     = (state == IDLE) && call_any && !any_ack;
    do_start   = accept && (call_sel == CALL_START);
    do_id      = accept && (call_sel == CALL_ID);
    do_px      = accept && (call_sel == CALL_PIXEL);
    do_px_oor  = do_px && !in_range;
    rd_cap     = (state == PX_RD);
    px_ack_set = (rd_cap && readf_q) || (state == PX_WR) || do_px_oor;
    // Reset is gated in so an edge coinciding with reset low never writes
    ram_we     = (state == PX_WR) && reset;
    resp_clr   = (state == RESP) && !cur_req;
  end

  // Registered outputs, flags and argument latches
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_ack           <= 1'b0;
      get_id_ack          <= 1'b0;
      setget_pixel_ack    <= 1'b0;
      get_id_return       <= '0;
      setget_pixel_return <= '0;
      started             <= 1'b0;
      call_q              <= CALL_START;
      readf_q             <= 1'b0;
      wdata_q             <= '0;
      addr_q              <= '0;
    end else begin
      if (accept) call_q <= call_sel;
      if (do_start) begin
        started   <= 1'b1;
        start_ack <= 1'b1;
      end
      if (do_id) begin
        get_id_return <= started ? SERVER_ID : '0;
        get_id_ack    <= 1'b1;
      end
      if (do_px) begin
        readf_q <= setget_pixel_readf;
        wdata_q <= setget_pixel_wdata;
        addr_q  <= addr_in;
      end
      if (do_px_oor)  setget_pixel_return <= '0;
      if (rd_cap)     setget_pixel_return <= ram_rdata;
      if (px_ack_set) setget_pixel_ack    <= 1'b1;
      if (resp_clr) begin
        start_ack        <= 1'b0;
        get_id_ack       <= 1'b0;
        setget_pixel_ack <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_test19_pixel_server.sv
// Scoreboard bench for test19_pixel_server: the client side pushes the
// expected call/return/latency for every call it issues; a monitor pops an
// entry on each rising ack and compares.
module tb_test19_pixel_server;

  localparam int W = 32;
  localparam int H = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_req = 1'b0, get_id_req = 1'b0, setget_pixel_req = 1'b0;
  logic        start_ack, get_id_ack, setget_pixel_ack;
  logic [15:0] get_id_return;
  logic [31:0] setget_pixel_axx = '0, setget_pixel_ayy = '0;
  logic        setget_pixel_readf = 1'b0;
  logic [7:0]  setget_pixel_wdata = '0;
  logic [7:0]  setget_pixel_return;

  test19_pixel_server #(
    .WIDTH     (W),
    .HEIGHT    (H),
    .SERVER_ID (16'h0013)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .start_req           (start_req),
    .start_ack           (start_ack),
    .get_id_req          (get_id_req),
    .get_id_ack          (get_id_ack),
    .get_id_return       (get_id_return),
    .setget_pixel_req    (setget_pixel_req),
    .setget_pixel_ack    (setget_pixel_ack),
    .setget_pixel_axx    (setget_pixel_axx),
    .setget_pixel_ayy    (setget_pixel_ayy),
    .setget_pixel_readf  (setget_pixel_readf),
    .setget_pixel_wdata  (setget_pixel_wdata),
    .setget_pixel_return (setget_pixel_return)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pixel bytes, whether each is known, started flag
  logic [7:0] mdl_mem   [W*H];
  bit         mdl_known [W*H];
  bit         mdl_started = 0;

  typedef struct {
    int call;   // 0 start, 1 get_id, 2 pixel
    int value;
    bit chk;    // compare value
    int lat;    // -1 = do not compare latency
  } exp_t;
  exp_t sb[$];

  // Monitor
  logic [2:0] prev_req = '0, prev_ack = '0;
  int rise [3];
  always @(negedge clk) begin
    logic [2:0] rq, ak;
    rq = {setget_pixel_req, get_id_req, start_req};
    ak = {setget_pixel_ack, get_id_ack, start_ack};
    if (!reset) begin
      prev_req = '0;
      prev_ack = '0;
    end else begin
      for (int c = 0; c < 3; c++) begin
        if (rq[c] && !prev_req[c]) rise[c] = cyc;
        if (ak[c] && !prev_ack[c]) begin
          if (sb.size() == 0) begin
            check("unexpected_ack", c, -1);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("ack_call", c, e.call);
            if (e.chk) begin
              if (c == 1) check("get_id_return", get_id_return, e.value);
              else if (c == 2) check("pixel_return", setget_pixel_return, e.value);
            end
            if (e.lat >= 0) check("ack_latency", cyc - rise[c], e.lat);
          end
        end
      end
      prev_req = rq;
      prev_ack = ak;
    end
  end

  // Compute and push the expectation of one call, updating the model
  task automatic expect_call(input int c, input logic [31:0] x, input logic [31:0] y,
                             input bit rd, input logic [7:0] wd, input int lat_ovr);
    exp_t e;
    longint idx;
    e.call = c; e.value = 0; e.chk = 1; e.lat = 1;
    if (c == 0) begin
      mdl_started = 1;
      e.chk = 0;
    end else if (c == 1) begin
      e.value = mdl_started ? 'h13 : 0;
    end else begin
      if (x < W && y < H) begin
        idx = longint'(y) * W + longint'(x);
        e.value = mdl_mem[idx];
        e.chk   = mdl_known[idx];
        e.lat   = rd ? 2 : 3;
        if (!rd) begin
          mdl_mem[idx]   = wd;
          mdl_known[idx] = 1;
        end
      end
    end
    if (lat_ovr != 0) e.lat = lat_ovr;
    sb.push_back(e);
  endtask

  task automatic set_req(input int c, input logic v);
    if (c == 0) start_req = v;
    else if (c == 1) get_id_req = v;
    else setget_pixel_req = v;
  endtask

  function automatic logic ack_of(input int c);
    return (c == 0) ? start_ack : (c == 1) ? get_id_ack : setget_pixel_ack;
  endfunction

  task automatic wait_ack(input int c, input logic lvl);
    int n;
    n = 0;
    while (ack_of(c) !== lvl && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (ack_of(c) !== lvl) check("handshake_timeout", c, lvl ? 16 : 32);
  endtask

  task automatic do_call(input int c, input logic [31:0] x, input logic [31:0] y,
                         input bit rd, input logic [7:0] wd);
    expect_call(c, x, y, rd, wd, 0);
    @(posedge clk); #1;
    setget_pixel_axx = x; setget_pixel_ayy = y;
    setget_pixel_readf = rd; setget_pixel_wdata = wd;
    set_req(c, 1'b1);
    @(negedge clk);
    wait_ack(c, 1'b1);
    @(posedge clk); #1;
    set_req(c, 1'b0);
    @(negedge clk);
    wait_ack(c, 1'b0);
  endtask

  task automatic check_reset_state();
    check("rst_start_ack", start_ack, 0);
    check("rst_get_id_ack", get_id_ack, 0);
    check("rst_pixel_ack", setget_pixel_ack, 0);
    check("rst_get_id_return", get_id_return, 0);
    check("rst_pixel_return", setget_pixel_return, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 check_reset_state();
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);

    // get_id before start, then start, then get_id
    do_call(1, 0, 0, 1, 0);
    do_call(0, 0, 0, 1, 0);
    do_call(1, 0, 0, 1, 0);

    // Seed known pixels, then write/read (3,5)
    do_call(2, 0, 0, 0, 8'h5A);
    do_call(2, 1, 1, 0, 8'h11);
    do_call(2, 3, 5, 0, 8'hA5);
    do_call(2, 3, 5, 1, 8'h00);

    // Out-of-range writes leave (0,0) alone
    do_call(2, 32, 0, 0, 8'h77);
    do_call(2, 0, 0, 1, 8'h00);
    do_call(2, 0, 32'hFFFF_FFFF, 0, 8'h77);
    do_call(2, 0, 0, 1, 8'h00);
    do_call(2, 32'h8000_0003, 5, 0, 8'h77);
    do_call(2, 3, 5, 1, 8'h00);

    // start and pixel read raised together: start wins
    expect_call(0, 0, 0, 1, 0, 0);
    expect_call(2, 3, 5, 1, 0, -1);
    @(posedge clk); #1;
    setget_pixel_axx = 3; setget_pixel_ayy = 5; setget_pixel_readf = 1;
    start_req = 1'b1; setget_pixel_req = 1'b1;
    @(negedge clk);
    wait_ack(0, 1'b1);
    check("pixel_ack_during_start", setget_pixel_ack, 0);
    @(posedge clk); #1 start_req = 1'b0;
    @(negedge clk);
    wait_ack(2, 1'b1);
    @(posedge clk); #1 setget_pixel_req = 1'b0;
    @(negedge clk);
    wait_ack(2, 1'b0);

    // Randomized calls
    for (int i = 0; i < 80; i++) begin
      int c;
      logic [31:0] x, y;
      c = $urandom_range(0, 9);
      c = (c == 0) ? 0 : (c == 1) ? 1 : 2;
      x = $urandom_range(0, 3);
      y = $urandom_range(0, 3);
      if ($urandom_range(0, 4) == 0) begin
        if ($urandom_range(0, 1) == 0) x = $urandom | 32'h20;
        else                           y = $urandom | 32'h20;
      end
      do_call(c, x, y, 1'($urandom_range(0, 1)), 8'($urandom));
    end

    // Reset while in PX_WR for (1,1): the write must be dropped
    do_call(2, 1, 1, 0, 8'h11);
    @(posedge clk); #1;
    setget_pixel_axx = 1; setget_pixel_ayy = 1;
    setget_pixel_readf = 0; setget_pixel_wdata = 8'h3C;
    setget_pixel_req = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    #1 check_reset_state();
    setget_pixel_req = 1'b0;
    mdl_started = 0;
    repeat (2) @(posedge clk);
    #1 check_reset_state();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    do_call(1, 0, 0, 1, 0);
    do_call(2, 1, 1, 1, 8'h00);

    for (int n = 0; n < 20 && sb.size() != 0; n++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
